lcd_ctrl: RTL and testbench

- Synthesizable controller for an HD44780-compatible character LCD in 4-bit mode.
- On reset, runs the power-up wait and initialization sequence autonomously.
- Then accepts byte writes (command or character) over a valid/ready handshake, splits each byte into two nibbles, generates E-strobe timing, and enforces per-command execution delays.
- Sits between application logic (text/cursor generators) and the board LCD pins; it is the only driver of those pins.

---
 rtl/lcd_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl -- write-only HD44780 character LCD controller, 4-bit bus mode.
//
// After reset the block waits out the LCD power-up time, then runs the fixed
// initialization sequence on its own. Four single nibbles are written, then
// four full bytes from an internal ROM. After that it accepts bytes (command
// or character) over a valid/ready handshake. Each byte goes out as two
// nibbles, each with its own E strobe, and is followed by the execution delay
// of that command.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   wr_valid   write request
//   wr_rs      0 = command, 1 = data (captured at accept)
//   wr_data    byte to write (captured at accept)
//   wr_ready   controller can accept a byte this cycle
//   init_done  initialization finished, sticky until reset
//   lcd_e      LCD enable strobe
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, always 0
//   lcd_data   LCD data bus D[7:4]
// ---------------------------------------------------------------------------
module lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 2,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_data
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_SETUP), max_of(T_EPW, T_HOLD)),
                                  max_of(max_of(T_NIB, T_CMD), max_of(max_of(T_CLR, T_INIT1), T_INIT2)));
    // A phase of N cycles loads N-1, so clog2(largest) bits are enough.
    localparam int CW = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    // Top-level sequence position. The four ROM bytes of the init sequence
    // reuse the WR_HI / WR_LO / WAIT path; init_done_q tells them apart.
    typedef enum logic [2:0] {
        S_PWRUP    = 3'd0,
        S_INIT_NIB = 3'd1,
        S_IDLE     = 3'd2,
        S_WR_HI    = 3'd3,
        S_WR_LO    = 3'd4,
        S_WAIT     = 3'd5
    } top_t;

    // Phase inside one nibble write; P_DLY is the wait that follows a nibble.
    typedef enum logic [1:0] {
        P_SETUP = 2'd0,
        P_PULSE = 2'd1,
        P_HOLD  = 2'd2,
        P_DLY   = 2'd3
    } ph_t;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h28;   // function set: 4-bit, 2 lines, 5x8
            2'd1:    b = 8'h06;   // entry mode: increment, no shift
            2'd2:    b = 8'h0C;   // display on, cursor off
            default: b = 8'h01;   // clear display
        endcase
        return b;
    endfunction

    function automatic logic [CW-1:0] init_wait(input logic [1:0] idx);
        logic [CW-1:0] w;
        case (idx)
            2'd0:    w = CW'(T_INIT1 - 1);
            2'd1:    w = CW'(T_INIT2 - 1);
            default: w = CW'(T_CMD - 1);
        endcase
        return w;
    endfunction

    top_t          top_q, top_d;
    ph_t           ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          lcd_e_q, lcd_e_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [3:0]    lcd_data_q, lcd_data_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic          nib_go_s;
    logic          nib_rs_s;
    logic [3:0]    nib_val_s;
    logic          clr_s;
    logic [1:0]    rom_idx_s;
    logic [7:0]    rom_byte_s;

    // In WAIT during init the next ROM entry is idx+1; leaving INIT_NIB starts at entry 0.
    assign rom_idx_s  = (top_q == S_WAIT) ? (idx_q + 2'd1) : 2'd0;
    assign rom_byte_s = init_rom(rom_idx_s);
    // Clear and home are the only slow commands.
    assign clr_s      = ~rs_q & ((byte_q == 8'h01) | (byte_q == 8'h02));

    // Next-state and next-output logic for the sequencer and timing counter.
    always_comb begin
        top_d      = top_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        lcd_e_d    = lcd_e_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        ready_d    = ready_q;
        done_d     = done_q;
        nib_go_s   = 1'b0;
        nib_rs_s   = 1'b0;
        nib_val_s  = 4'h0;

        case (top_q)
            S_PWRUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    top_d     = S_INIT_NIB;
                    idx_d     = 2'd0;
                    nib_go_s  = 1'b1;
                    nib_val_s = 4'h3;
                end
            end

            S_INIT_NIB, S_WR_HI, S_WR_LO: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    case (ph_q)
                        P_SETUP: begin
                            ph_d    = P_PULSE;
                            cnt_d   = CW'(T_EPW - 1);
                            lcd_e_d = 1'b1;
                        end
                        P_PULSE: begin
                            ph_d    = P_HOLD;
                            cnt_d   = CW'(T_HOLD - 1);
                            lcd_e_d = 1'b0;
                        end
                        P_HOLD: begin
                            if (top_q == S_INIT_NIB) begin
                                ph_d  = P_DLY;
                                cnt_d = init_wait(idx_q);
                            end else if (top_q == S_WR_HI) begin
                                ph_d  = P_DLY;
                                cnt_d = CW'(T_NIB - 1);
                            end else begin
                                top_d = S_WAIT;
                                cnt_d = clr_s ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
                            end
                        end
                        default: begin   // P_DLY
                            if (top_q == S_INIT_NIB) begin
                                if (idx_q == 2'd3) begin
                                    top_d     = S_WR_HI;
                                    idx_d     = 2'd0;
                                    byte_d    = rom_byte_s;
                                    rs_d      = 1'b0;
                                    nib_go_s  = 1'b1;
                                    nib_val_s = rom_byte_s[7:4];
                                end else begin
                                    idx_d     = idx_q + 2'd1;
                                    nib_go_s  = 1'b1;
                                    nib_val_s = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                                end
                            end else if (top_q == S_WR_HI) begin
                                top_d     = S_WR_LO;
                                nib_go_s  = 1'b1;
                                nib_rs_s  = rs_q;
                                nib_val_s = byte_q[3:0];
                            end else begin
                                // WR_LO never delays in place; recover via WAIT.
                                top_d = S_WAIT;
                                cnt_d = CW'(T_CMD - 1);
                            end
                        end
                    endcase
                end
            end

            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!done_q && (idx_q != 2'd3)) begin
                    top_d     = S_WR_HI;
                    idx_d     = rom_idx_s;
                    byte_d    = rom_byte_s;
                    rs_d      = 1'b0;
                    nib_go_s  = 1'b1;
                    nib_val_s = rom_byte_s[7:4];
                end else begin
                    top_d   = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end

            S_IDLE: begin
                if (wr_valid && ready_q) begin
                    top_d     = S_WR_HI;
                    byte_d    = wr_data;
                    rs_d      = wr_rs;
                    ready_d   = 1'b0;
                    nib_go_s  = 1'b1;
                    nib_rs_s  = wr_rs;
                    nib_val_s = wr_data[7:4];
                end else begin
                    top_d = S_IDLE;
                end
            end

            default: begin
                top_d   = S_PWRUP;
                ph_d    = P_SETUP;
                cnt_d   = CW'(T_PWRUP - 1);
                lcd_e_d = 1'b0;
                ready_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Bus lines only change when a nibble write begins.
        if (nib_go_s) begin
            ph_d       = P_SETUP;
            cnt_d      = CW'(T_SETUP - 1);
            lcd_e_d    = 1'b0;
            lcd_rs_d   = nib_rs_s;
            lcd_data_d = nib_val_s;
        end else begin
            lcd_rs_d   = lcd_rs_d;
        end
    end

    // State, counter and registered outputs; reset clears the pins at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            top_q      <= S_PWRUP;
            ph_q       <= P_SETUP;
            cnt_q      <= CW'(T_PWRUP - 1);
            idx_q      <= 2'd0;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 4'h0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            top_q      <= top_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = lcd_data_q;
    assign wr_ready  = ready_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_ctrl -- self-checking bench for lcd_ctrl with shortened timing.
// A waveform model expands each nibble/byte into the per-cycle pin values the
// LCD protocol requires, and the compare process checks every cycle against
// it. A monitor records strobe edges so that directed checks can pin the
// model against hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_lcd_ctrl;

    localparam int P_PWRUP = 10;
    localparam int P_SETUP = 1;
    localparam int P_EPW   = 3;
    localparam int P_HOLD  = 1;
    localparam int P_NIB   = 4;
    localparam int P_CMD   = 8;
    localparam int P_CLR   = 20;
    localparam int P_INIT1 = 15;
    localparam int P_INIT2 = 6;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready, init_done, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EPW(P_EPW), .T_HOLD(P_HOLD),
        .T_NIB(P_NIB), .T_CMD(P_CMD), .T_CLR(P_CLR), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2)
    ) dut (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .init_done(init_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural waveform model ----------------
    typedef struct packed {
        logic       e;
        logic       rs;
        logic [3:0] d;
        logic       rdy;
        logic       done;
    } smp_t;

    smp_t       exp_q[$];
    logic       tail_rs;
    logic [3:0] tail_d;
    logic [7:0] init_bytes [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};

    task automatic add_cyc(input int n, input logic e, input logic rdy, input logic done);
        for (int i = 0; i < n; i++) exp_q.push_back('{e: e, rs: tail_rs, d: tail_d, rdy: rdy, done: done});
    endtask

    task automatic add_nib(input logic rs, input logic [3:0] v, input logic rdy, input logic done);
        tail_rs = rs;
        tail_d  = v;
        add_cyc(P_SETUP, 1'b0, rdy, done);
        add_cyc(P_EPW,   1'b1, rdy, done);
        add_cyc(P_HOLD,  1'b0, rdy, done);
    endtask

    task automatic add_byte(input logic rs, input logic [7:0] b, input logic done);
        add_nib(rs, b[7:4], 1'b0, done);
        add_cyc(P_NIB, 1'b0, 1'b0, done);
        add_nib(rs, b[3:0], 1'b0, done);
        add_cyc((!rs && (b == 8'h01 || b == 8'h02)) ? P_CLR : P_CMD, 1'b0, 1'b0, done);
    endtask

    task automatic build_init();
        exp_q.delete();
        tail_rs = 1'b0;
        tail_d  = 4'h0;
        add_cyc(P_PWRUP, 1'b0, 1'b0, 1'b0);
        add_nib(1'b0, 4'h3, 1'b0, 1'b0); add_cyc(P_INIT1, 1'b0, 1'b0, 1'b0);
        add_nib(1'b0, 4'h3, 1'b0, 1'b0); add_cyc(P_INIT2, 1'b0, 1'b0, 1'b0);
        add_nib(1'b0, 4'h3, 1'b0, 1'b0); add_cyc(P_CMD,   1'b0, 1'b0, 1'b0);
        add_nib(1'b0, 4'h2, 1'b0, 1'b0); add_cyc(P_CMD,   1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add_byte(1'b0, init_bytes[i], 1'b0);
    endtask

    // Compare process: one model step per clock, checked at the falling edge.
    always @(negedge clk) begin
        smp_t e_s;
        if (!rstn) begin
            check("reset_outputs", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data, wr_ready, init_done}), 32'(0));
            build_init();
        end else begin
            if (exp_q.size() > 0) e_s = exp_q.pop_front();
            else e_s = '{e: 1'b0, rs: tail_rs, d: tail_d, rdy: 1'b1, done: 1'b1};
            check("cycle_pins{e,rs,rw,d,rdy,done}",
                  32'({lcd_e, lcd_rs, lcd_rw, lcd_data, wr_ready, init_done}),
                  32'({e_s.e, e_s.rs, 1'b0, e_s.d, e_s.rdy, e_s.done}));
            if (e_s.rdy && wr_valid) add_byte(wr_rs, wr_data, 1'b1);
        end
    end

    // ---------------- event monitor ----------------
    int         cyc, n_rise, rdy_cyc, acc_cyc;
    logic       e_prev, rdy_prev;
    logic [3:0] rise_nib [64];
    logic       rise_rs  [64];
    int         rise_cyc [64];

    always @(negedge clk) begin
        if (!rstn) begin
            cyc = 0; n_rise = 0; rdy_cyc = -1; acc_cyc = -1;
            e_prev = 1'b0; rdy_prev = 1'b0;
        end else begin
            if (lcd_e && !e_prev) begin
                rise_nib[n_rise[5:0]] = lcd_data;
                rise_rs[n_rise[5:0]]  = lcd_rs;
                rise_cyc[n_rise[5:0]] = cyc;
                n_rise++;
            end
            if (wr_ready && !rdy_prev) rdy_cyc = cyc;
            if (wr_ready && wr_valid) acc_cyc = cyc;
            e_prev   = lcd_e;
            rdy_prev = wr_ready;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic rs, input logic [7:0] b, output int acc);
        int g;
        g = 0;
        wr_valid = 1'b1; wr_rs = rs; wr_data = b;
        @(negedge clk); #1;
        while (!wr_ready && g < 200) begin
            @(negedge clk); #1;
            g++;
        end
        if (!wr_ready) check("accept_timeout", 32'(wr_ready), 32'(1));
        acc = acc_cyc;
        tick();
    endtask

    task automatic wait_ready(input int acc, output int r);
        int g;
        g = 0;
        while (!(rdy_cyc > acc) && g < 300) begin
            tick();
            g++;
        end
        if (!(rdy_cyc > acc)) check("ready_timeout", 32'(0), 32'(1));
        r = rdy_cyc;
    endtask

    logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

    // Runs from release to IDLE; optionally pokes wr_valid early in init.
    task automatic init_phase(input logic poke);
        int g;
        g = 0;
        while (rdy_cyc < 0 && g < 400) begin
            if (poke && g < 120) begin
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_rs    = 1'($urandom_range(0, 1));
                wr_data  = 8'($urandom);
            end else begin
                wr_valid = 1'b0;
            end
            tick();
            g++;
        end
        wr_valid = 1'b0;
        check("init_ready_cycle", 32'(rdy_cyc), 32'(167));
        check("init_pulse_count", 32'(n_rise), 32'(12));
        check("init_first_rise_cycle", 32'(rise_cyc[0]), 32'(11));
        for (int i = 0; i < 12; i++) begin
            check("init_nibble", 32'({rise_rs[i], rise_nib[i]}), 32'({1'b0, init_nibs[i]}));
        end
        repeat (10) tick();
        check("idle_no_extra_pulse", 32'(n_rise), 32'(12));
        check("init_done_sticky", 32'(init_done), 32'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a, a2, r, n0;

        repeat (3) tick();
        rstn = 1'b1;
        init_phase(1'b1);

        // character write
        n0 = n_rise;
        send(1'b1, 8'h41, a);
        wr_valid = 1'b0;
        wait_ready(a, r);
        check("wr41_latency", 32'(r - a), 32'(23));
        check("wr41_pulses", 32'(n_rise - n0), 32'(2));
        check("wr41_hi", 32'({rise_rs[n0[5:0]], rise_nib[n0[5:0]]}), 32'(5'h14));
        check("wr41_lo", 32'({rise_rs[6'(n0 + 1)], rise_nib[6'(n0 + 1)]}), 32'(5'h11));
        check("wr41_e_low_gap", 32'(rise_cyc[6'(n0 + 1)] - rise_cyc[n0[5:0]] - P_EPW), 32'(6));

        // clear as command, then the same byte as data
        send(1'b0, 8'h01, a);
        wr_valid = 1'b0;
        wait_ready(a, r);
        check("clear_latency", 32'(r - a), 32'(35));
        send(1'b1, 8'h01, a);
        wr_valid = 1'b0;
        wait_ready(a, r);
        check("data01_latency", 32'(r - a), 32'(23));

        // back-to-back with wr_valid held high
        n0 = n_rise;
        send(1'b1, 8'h48, a);
        send(1'b1, 8'h49, a2);
        wr_valid = 1'b0;
        check("b2b_accept_gap", 32'(a2 - a), 32'(23));
        wait_ready(a2, r);
        check("b2b_pulses", 32'(n_rise - n0), 32'(4));
        for (int i = 0; i < 4; i++) begin
            check("b2b_nibble", 32'(rise_nib[6'(n0 + i)]), 32'((i % 2 == 0) ? 4 : ((i == 1) ? 8 : 9)));
        end

        // free-running random traffic, checked cycle by cycle by the model
        for (int i = 0; i < 300; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_rs    = 1'($urandom_range(0, 1));
            wr_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            tick();
        end

        // asynchronous reset in the middle of an E-high phase
        send(1'b1, 8'h5A, a);
        wr_valid = 1'b0;
        begin
            int g;
            g = 0;
            while (lcd_e !== 1'b1 && g < 50) begin
                tick();
                g++;
            end
        end
        check("e_high_before_reset", 32'(lcd_e), 32'(1));
        rstn = 1'b0;
        #1;
        check("async_reset_pins", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data, wr_ready, init_done}), 32'(0));
        repeat (3) tick();
        rstn = 1'b1;
        init_phase(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
